ata_pio_seq: RTL and testbench
==============================

# ata_pio_seq

Single-transfer ATA PIO access sequencer for the OCIDEC-1 host core. It sits directly upstream of the run-once down-counter and drives it through three timing phases per host request: address setup (t1), strobe active (t2, optionally stretched by IORDY), and end-of-cycle recovery (teoc). It produces the device-side strobes, the data-bus output enable, the captured read data, and a one-cycle completion pulse.

## Interface
Parameters:
- TWIDTH, 8, width of each timing value; phase length is value+1 cycles
- DWIDTH, 16, ATA data bus width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  master clock
- rst  in  1  asynchronous active-high reset
- go  in  1  start request; accepted only when busy=0
- we  in  1  1=write, 0=read; sampled with go
- t1  in  TWIDTH  address-setup cycles minus one; sampled with go
- t2  in  TWIDTH  strobe-active cycles minus one; sampled with go
- teoc  in  TWIDTH  recovery cycles minus one; sampled with go
- iordy_en  in  1  enable IORDY stretching; sampled with go
- iordy  in  1  asynchronous device IORDY
- wdat  in  DWIDTH  write data; sampled with go
- dd_i  in  DWIDTH  device data bus input
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- dior  out  1  read strobe, active high
- diow  out  1  write strobe, active high
- dd_o  out  DWIDTH  device data bus output
- dd_oe  out  1  data bus output enable
- rdat  out  DWIDTH  captured read data, held until next read completes

## Operation
- States: IDLE, T1, T2, WAIT, TEOC.
- IDLE: go=1 latches we, t1, t2, teoc, iordy_en, wdat; counter loaded with t1; next T1. go while busy ignored, no queuing.
- T1: strobes low. On counter done -> T2, counter loaded with t2; asserting strobe (dior if read, diow if write) takes effect in same transition.
- T2: strobe high. On counter done: if iordy_en=1 and synchronized iordy=0 -> WAIT, else -> TEOC with counter loaded with teoc.
- WAIT: strobe held high; leave to TEOC on first cycle synchronized iordy=1; no timeout.
- Read data: rdat <= dd_i on the edge leaving T2 or WAIT into TEOC (strobe still high that cycle).
- TEOC: strobes low. On counter done -> IDLE, done=1 for that one cycle.
- dd_o = latched wdat; dd_oe=1 from T1 through TEOC for writes, 0 for reads and IDLE.
- iordy passes through a 2-flop synchronizer reset to 1; latency 2 cycles counts toward stretching.
- Reset values: busy=0, done=0, dior=0, diow=0, dd_oe=0, dd_o=0, rdat=0, state IDLE. Reset mid-transfer aborts immediately: strobes and dd_oe drop asynchronously, no done pulse.

## Timing
- go at edge k (IDLE) -> busy=1 from k+1; T1 occupies t1+1 cycles.
- Strobe high for exactly t2+1 cycles when not stretched; plus WAIT cycles otherwise.
- TEOC occupies teoc+1 cycles; done high during the final TEOC clock's following cycle in IDLE, busy=0 same cycle; go accepted that cycle.
- Unstretched total: busy high t1+t2+teoc+3 cycles. All-zero timing gives 3 cycles.
- Strobes, dd_oe, done are registered outputs; no combinational path from any input to any output.
- Timing values are wrap-free: maximum phase 2^TWIDTH cycles; inputs changing after go have no effect.

## Structure
- Shared package: state encoding constants (IDLE, T1, T2, WAIT, TEOC) and default TWIDTH/DWIDTH, reused by the DMA sequencer.
- One sub-module: ro_cnt, SIZE=TWIDTH, nReset tied to ~rst, rst=0, cnt_en=1; go pulsed on each phase load, d muxed from latched t1/t2/teoc; its done drives phase exit.

## Test plan
- Read, t1=2 t2=4 teoc=1, iordy_en=0, dd_i=16'hA55A -> dior high 5 cycles, busy 10 cycles, rdat=16'hA55A, done single pulse.
- Write, t1=0 t2=0 teoc=0, wdat=16'h1234 -> busy 3 cycles, diow high 1 cycle, dd_oe high 3 cycles, dd_o=16'h1234.
- Read, t2=3, iordy_en=1, iordy low for 6 cycles around T2 -> dior stretched until 2 cycles after iordy rises; rdat captured at exit.
- Same stretch with iordy_en=0 -> dior exactly 4 cycles, iordy ignored.
- go pulsed during busy and t1 changed mid-transfer -> no second transfer, original timing retained; go in done cycle starts next transfer immediately.
- rst asserted in T2 of a write -> diow, dd_oe, busy low asynchronously, no done; next go runs normally.

Source files
------------

// File: rtl/ata_pio_seq_pkg.sv
// Shared constants for the OCIDEC-1 PIO/DMA access sequencers.
package ata_pio_seq_pkg;

    // Default widths of the timing values and the ATA data bus
    localparam int unsigned DefTwidth = 8;
    localparam int unsigned DefDwidth = 16;

    // Sequencer state encoding, shared with the DMA sequencer
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StT1   = 3'd1;
    localparam logic [2:0] StT2   = 3'd2;
    localparam logic [2:0] StWait = 3'd3;
    localparam logic [2:0] StTeoc = 3'd4;

endpackage

// File: rtl/ata_pio_seq_ro_cnt.sv
// Run-once down-counter: go loads d, then counts to zero and stops.
// done is high for the cycle the count sits at zero, so a load of v gives a
// phase of v+1 cycles.
module ata_pio_seq_ro_cnt #(
    parameter int unsigned SIZE = 8
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            rst,
    input  logic            cnt_en,
    input  logic            go,
    input  logic [SIZE-1:0] d,
    output logic            done
);

    logic [SIZE-1:0] cnt_q;
    logic            run_q;

    // Load on go, otherwise count down while running and stop at zero
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (go) begin
            cnt_q <= d;
            run_q <= 1'b1;
        end else if (cnt_en && run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/ata_pio_seq.sv
// Single-transfer ATA PIO access sequencer: address setup, strobe (optionally
// stretched by IORDY) and end-of-cycle recovery, timed by a run-once counter.
module ata_pio_seq
    import ata_pio_seq_pkg::*;
#(
    parameter int unsigned TWIDTH = DefTwidth,
    parameter int unsigned DWIDTH = DefDwidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              we,
    input  logic [TWIDTH-1:0] t1,
    input  logic [TWIDTH-1:0] t2,
    input  logic [TWIDTH-1:0] teoc,
    input  logic              iordy_en,
    input  logic              iordy,
    input  logic [DWIDTH-1:0] wdat,
    input  logic [DWIDTH-1:0] dd_i,
    output logic              busy,
    output logic              done,
    output logic              dior,
    output logic              diow,
    output logic [DWIDTH-1:0] dd_o,
    output logic              dd_oe,
    output logic [DWIDTH-1:0] rdat
);

    logic [2:0]        state_q, state_d;
    logic              we_q, iordy_en_q;
    logic [TWIDTH-1:0] t2_q, teoc_q;
    logic [DWIDTH-1:0] wdat_q, rdat_q;
    logic              iordy_s1_q, iordy_s2_q;
    logic              dior_q, diow_q, dd_oe_q, done_q;
    logic              accept, capture, strobe_d, we_d;
    logic              cnt_go, cnt_done;
    logic [TWIDTH-1:0] cnt_d;

    // Two-flop IORDY synchronizer; idles ready so reset never stretches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iordy_s1_q <= 1'b1;
            iordy_s2_q <= 1'b1;
        end else begin
            iordy_s1_q <= iordy;
            iordy_s2_q <= iordy_s1_q;
        end
    end

    // Phase sequencing and counter load selection
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        cnt_go  = 1'b0;
        cnt_d   = t2_q;
        case (state_q)
            StIdle: begin
                if (go) begin
                    // t1 is consumed straight from the port at the accepting edge
                    accept  = 1'b1;
                    cnt_go  = 1'b1;
                    cnt_d   = t1;
                    state_d = StT1;
                end
            end
            StT1: begin
                if (cnt_done) begin
                    cnt_go  = 1'b1;
                    cnt_d   = t2_q;
                    state_d = StT2;
                end
            end
            StT2: begin
                if (cnt_done) begin
                    if (iordy_en_q && !iordy_s2_q) begin
                        state_d = StWait;
                    end else begin
                        capture = 1'b1;
                        cnt_go  = 1'b1;
                        cnt_d   = teoc_q;
                        state_d = StTeoc;
                    end
                end
            end
            StWait: begin
                if (iordy_s2_q) begin
                    capture = 1'b1;
                    cnt_go  = 1'b1;
                    cnt_d   = teoc_q;
                    state_d = StTeoc;
                end
            end
            StTeoc: begin
                if (cnt_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign we_d     = accept ? we : we_q;
    assign strobe_d = (state_d == StT2) || (state_d == StWait);

    // State, latched request and registered device-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            iordy_en_q <= 1'b0;
            t2_q       <= '0;
            teoc_q     <= '0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            dior_q     <= 1'b0;
            diow_q     <= 1'b0;
            dd_oe_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q       <= we;
                iordy_en_q <= iordy_en;
                t2_q       <= t2;
                teoc_q     <= teoc;
                wdat_q     <= wdat;
            end
            // Strobe is still high in the cycle that leaves T2/WAIT
            if (capture && !we_q) begin
                rdat_q <= dd_i;
            end
            dior_q  <= strobe_d && !we_d;
            diow_q  <= strobe_d && we_d;
            dd_oe_q <= (state_d != StIdle) && we_d;
            done_q  <= (state_q == StTeoc) && cnt_done;
        end
    end

    ata_pio_seq_ro_cnt #(
        .SIZE (TWIDTH)
    ) u_cnt (
        .clk    (clk),
        .nReset (~rst),
        .rst    (1'b0),
        .cnt_en (1'b1),
        .go     (cnt_go),
        .d      (cnt_d),
        .done   (cnt_done)
    );

    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign dior  = dior_q;
    assign diow  = diow_q;
    assign dd_oe = dd_oe_q;
    assign dd_o  = wdat_q;
    assign rdat  = rdat_q;

endmodule

// File: tb/tb_ata_pio_seq.sv
// Directed bench for ata_pio_seq: a per-cycle expected-waveform model built
// from the phase lengths of each accepted request, plus literal checks.
module tb_ata_pio_seq;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        we = 1'b0;
    logic        iordy_en = 1'b0;
    logic        iordy = 1'b1;
    logic [7:0]  t1 = '0, t2 = '0, teoc = '0;
    logic [15:0] wdat = '0, dd_i = '0;
    logic        busy, done, dior, diow, dd_oe;
    logic [15:0] dd_o, rdat;

    ata_pio_seq #(
        .TWIDTH (8),
        .DWIDTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .we       (we),
        .t1       (t1),
        .t2       (t2),
        .teoc     (teoc),
        .iordy_en (iordy_en),
        .iordy    (iordy),
        .wdat     (wdat),
        .dd_i     (dd_i),
        .busy     (busy),
        .done     (done),
        .dior     (dior),
        .diow     (diow),
        .dd_o     (dd_o),
        .dd_oe    (dd_oe),
        .rdat     (rdat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;  // index of the last rising edge; cycle n follows edge n

    bit          plan_lo[MAXC];  // iordy sampled low at edge n
    bit          e_busy[MAXC], e_done[MAXC], e_dior[MAXC], e_diow[MAXC], e_oe[MAXC];
    logic [15:0] e_ddo[MAXC], e_rdat[MAXC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit iordy_at(input int e);
        if (e < 0 || e >= MAXC) return 1'b1;
        return !plan_lo[e];
    endfunction

    // Expected waveform of a request accepted at edge k
    task automatic schedule(input int k);
        int a, c, w, fin;
        a = k + 1 + int'(t1);       // first strobe cycle
        c = a + int'(t2) + 1;       // first cycle after the nominal strobe
        if (iordy_en && !iordy_at(c - 2)) begin
            w = c;
            while (!iordy_at(w - 1) && w < MAXC) w++;
            c = w + 1;
        end
        fin = c + int'(teoc);       // last recovery cycle
        for (int n = k; n <= fin && n < MAXC; n++) begin
            e_busy[n] = 1'b1;
            e_oe[n]   = we;
        end
        for (int n = a; n < c && n < MAXC; n++) begin
            e_dior[n] = !we;
            e_diow[n] = we;
        end
        if (fin + 1 < MAXC) e_done[fin + 1] = 1'b1;
        for (int n = k; n < MAXC; n++) e_ddo[n] = wdat;
        if (!we) for (int n = c; n < MAXC; n++) e_rdat[n] = dd_i;
    endtask

    task automatic model_clear();
        for (int n = cyc; n < MAXC; n++) begin
            e_busy[n] = 1'b0;
            e_done[n] = 1'b0;
            e_dior[n] = 1'b0;
            e_diow[n] = 1'b0;
            e_oe[n]   = 1'b0;
            e_ddo[n]  = '0;
            e_rdat[n] = '0;
        end
    endtask

    // Model: accept go only when the previous cycle was idle
    initial begin
        for (int n = 0; n < MAXC; n++) begin
            e_ddo[n]  = '0;
            e_rdat[n] = '0;
        end
        forever begin
            @(posedge clk);
            if (!rst && go && !e_busy[cyc]) schedule(cyc + 1);
            cyc = cyc + 1;
        end
    end

    // IORDY driver: value for the coming edge
    initial forever begin
        @(negedge clk);
        iordy = (cyc + 1 < MAXC) ? !plan_lo[cyc + 1] : 1'b1;
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("busy",  32'(busy),  32'(e_busy[cyc]));
            check("done",  32'(done),  32'(e_done[cyc]));
            check("dior",  32'(dior),  32'(e_dior[cyc]));
            check("diow",  32'(diow),  32'(e_diow[cyc]));
            check("dd_oe", 32'(dd_oe), 32'(e_oe[cyc]));
            check("dd_o",  32'(dd_o),  32'(e_ddo[cyc]));
            check("rdat",  32'(rdat),  32'(e_rdat[cyc]));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    // Present a request between edges; returns one tick after the accepting edge
    task automatic start_xfer(input bit w, input logic [7:0] a1, input logic [7:0] a2,
                              input logic [7:0] a3, input bit en, input logic [15:0] wd,
                              input logic [15:0] dd, input int lo_s, input int lo_n);
        int k;
        k = cyc + 1;
        for (int i = 0; i < lo_n; i++) begin
            if (k + lo_s + i < MAXC) plan_lo[k + lo_s + i] = 1'b1;
        end
        we = w; t1 = a1; t2 = a2; teoc = a3; iordy_en = en; wdat = wd; dd_i = dd;
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    // Count active cycles until the done pulse; optional go poke mid-transfer
    task automatic measure(input int poke, output int nb, output int nr, output int nw,
                           output int noe);
        bit seen;
        seen = 1'b0;
        nb = 0; nr = 0; nw = 0; noe = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (i == poke) begin
                go = 1'b1;
                t1 = 8'd9;
            end
            if (i == poke + 1) go = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                nb  += int'(busy);
                nr  += int'(dior);
                nw  += int'(diow);
                noe += int'(dd_oe);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    int nb, nr, nw, noe;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_dior",  32'(dior),  32'd0);
        check("rst_diow",  32'(diow),  32'd0);
        check("rst_dd_oe", 32'(dd_oe), 32'd0);
        check("rst_dd_o",  32'(dd_o),  32'd0);
        check("rst_rdat",  32'(rdat),  32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Plain read
        start_xfer(1'b0, 8'd2, 8'd4, 8'd1, 1'b0, 16'h0000, 16'hA55A, 0, 0);
        measure(-10, nb, nr, nw, noe);
        check("rd_busy_cycles", 32'(nb), 32'd10);
        check("rd_dior_cycles", 32'(nr), 32'd5);
        check("rd_diow_cycles", 32'(nw), 32'd0);
        check("rd_oe_cycles",   32'(noe), 32'd0);
        check("rd_rdat",        32'(rdat), 32'hA55A);
        @(negedge clk);
        check("rd_done_single", 32'(done), 32'd0);

        // Minimal write
        start_xfer(1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 16'h1234, 16'h0000, 0, 0);
        measure(-10, nb, nr, nw, noe);
        check("wr_busy_cycles", 32'(nb), 32'd3);
        check("wr_diow_cycles", 32'(nw), 32'd1);
        check("wr_dior_cycles", 32'(nr), 32'd0);
        check("wr_oe_cycles",   32'(noe), 32'd3);
        check("wr_dd_o",        32'(dd_o), 32'h1234);

        // IORDY stretch: low for edges k+2..k+7
        @(negedge clk);
        start_xfer(1'b0, 8'd0, 8'd3, 8'd0, 1'b1, 16'h0000, 16'h5AA5, 2, 6);
        measure(-10, nb, nr, nw, noe);
        check("st_dior_cycles", 32'(nr), 32'd9);
        check("st_busy_cycles", 32'(nb), 32'd11);
        check("st_rdat",        32'(rdat), 32'h5AA5);

        // Same IORDY pattern, stretching disabled
        @(negedge clk);
        start_xfer(1'b0, 8'd0, 8'd3, 8'd0, 1'b0, 16'h0000, 16'h0F0F, 2, 6);
        measure(-10, nb, nr, nw, noe);
        check("ns_dior_cycles", 32'(nr), 32'd4);
        check("ns_busy_cycles", 32'(nb), 32'd6);
        check("ns_rdat",        32'(rdat), 32'h0F0F);

        // go and t1 poked while busy, then back-to-back start in the done cycle
        @(negedge clk);
        start_xfer(1'b0, 8'd2, 8'd1, 8'd1, 1'b0, 16'h0000, 16'h1111, 0, 0);
        measure(2, nb, nr, nw, noe);
        check("ig_busy_cycles", 32'(nb), 32'd7);
        check("ig_dior_cycles", 32'(nr), 32'd2);
        start_xfer(1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 16'h7E7E, 16'h0000, 0, 0);
        check("b2b_busy_now", 32'(busy), 32'd1);
        measure(-10, nb, nr, nw, noe);
        check("b2b_busy_cycles", 32'(nb), 32'd3);
        check("b2b_diow_cycles", 32'(nw), 32'd1);

        // Reset during the strobe of a write
        @(negedge clk);
        start_xfer(1'b1, 8'd1, 8'd5, 8'd1, 1'b0, 16'hBEEF, 16'h0000, 0, 0);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(negedge clk);
                if (diow) hit = 1'b1;
            end
            check("rs_reached_t2", 32'(hit), 32'd1);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        model_clear();
        #1;
        check("rs_diow",  32'(diow),  32'd0);
        check("rs_dd_oe", 32'(dd_oe), 32'd0);
        check("rs_busy",  32'(busy),  32'd0);
        check("rs_done",  32'(done),  32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Normal transfer after the abort
        start_xfer(1'b0, 8'd1, 8'd2, 8'd2, 1'b0, 16'h0000, 16'hC3C3, 0, 0);
        measure(-10, nb, nr, nw, noe);
        check("pr_busy_cycles", 32'(nb), 32'd8);
        check("pr_dior_cycles", 32'(nr), 32'd3);
        check("pr_rdat",        32'(rdat), 32'hC3C3);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
